// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: each stage resolves one CW-bit chunk of the carry chain.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH (%0d) must be divisible by STAGES (%0d)", WIDTH, STAGES);
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipe_adder: STAGES (%0d) must be in 1..8", STAGES);
  end

  // Global stall: the whole pipe freezes while the output beat is not taken.
  logic              stall;
  logic              en;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~stall;
  assign vld_pipe  = {vld_q, in_valid & in_ready};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Stage k inputs: a_s carries resolved low chunks plus untouched upper A,
  // b_s carries effective B (already inverted for subtract), c_s the chunk carry-in.
  logic [STAGES-1:0][WIDTH-1:0] a_s;
  logic [STAGES-1:0][WIDTH-1:0] b_s;
  logic [STAGES-1:0]            c_s;

  assign a_s[0] = a;
  assign b_s[0] = b ^ {WIDTH{sub}};
  assign c_s[0] = sub;

`ifdef PIPE_ADDER_SAT_EN
  logic [STAGES-1:0] sat_s;
  assign sat_s[0] = sat;
`endif

  logic [WIDTH-1:0] y_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      sum;
    logic [WIDTH-1:0] res;

    assign sum = {1'b0, a_s[k][k*CW +: CW]} + {1'b0, b_s[k][k*CW +: CW]} + {{CW{1'b0}}, c_s[k]};

    always_comb begin
      res               = a_s[k];
      res[k*CW +: CW]   = sum[CW-1:0];
    end

    if (k < STAGES-1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;
`ifdef PIPE_ADDER_SAT_EN
      logic             sat_q;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (en) begin
          a_q   <= res;
          b_q   <= b_s[k];
          c_q   <= sum[CW];
`ifdef PIPE_ADDER_SAT_EN
          sat_q <= sat_s[k];
`endif
        end
      end

      assign a_s[k+1]   = a_q;
      assign b_s[k+1]   = b_q;
      assign c_s[k+1]   = c_q;
`ifdef PIPE_ADDER_SAT_EN
      assign sat_s[k+1] = sat_q;
`endif
    end else begin : g_last
      logic             ovf_d;
      logic [WIDTH-1:0] y_d;

      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      assign ovf_d = res[WIDTH-1] ^ a_s[k][WIDTH-1] ^ b_s[k][WIDTH-1] ^ sum[CW];

`ifdef PIPE_ADDER_SAT_EN
      // On overflow the wrapped sign is the inverse of the true sign.
      always_comb begin
        y_d = res;
        if (sat_s[k] && ovf_d)
          y_d = res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end
`else
      assign y_d = res;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q    <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          y_q    <= y_d;
          cout_q <= sum[CW];
          ovf_q  <= ovf_d;
          zero_q <= (y_d == '0);
        end
      end
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined add/subtract unit replacing the single-cycle 32-bit adder on timing-critical paths, such as the branch-target and address-generation feeds in the EX stage. Each pipeline stage resolves one chunk of the carry chain, so a WIDTH-bit add completes in STAGES cycles at one operation per cycle. Valid/ready handshake on input and output. Carry, signed-overflow and zero flags are carried with each result.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, number of register stages (latency); 1..8; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: y=a+b; 1: y=a-b (a + ~b + 1)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB (for sub, 1 = no borrow)
ovf  output  1  signed two's-complement overflow
zero  output  1  y == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, y, cout, ovf and zero are cleared to 0. zero also resets to 0, not 1. Any in-flight beats are discarded, with no partial output after release. in_ready is combinational and reads 1 during and after reset.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage register holds its value.
  - Global stall is used; bubbles are not compressed.
- Accept: a beat is taken when in_valid & in_ready.
  - Stage 0 latches chunk 0 sum: a[CW-1:0] + (b^{WIDTH{sub}})[CW-1:0] + sub.
  - Stage 0 also latches its carry, the upper chunks of a and b-effective, and sub.
- Stage k (1..STAGES-1): adds chunk k plus the carry from stage k-1. It forwards the already-resolved low chunks and the remaining upper chunks.
- Sign information: the last stage forms the MSB carry-in and carry-out, giving ovf = c_in_msb ^ c_out_msb. cout = final carry.
- Latency: a beat accepted at edge n is presented with out_valid=1 after edge n+STAGES-1, i.e. registered output visible STAGES cycles after the accept, when no stall occurs.
- Throughput: one beat per cycle while out_ready=1. Order is preserved; no beat is dropped or duplicated.
- Output holding: the output holds y/flags stable while out_valid & ~out_ready.
- Bubbles: when in_valid=0, the stage valid bit is 0. Data registers may hold stale values; out_valid=0 then.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- STAGES=1: single register stage, latency 1, full-width add in one cycle.
- Wrap-around: result is modulo 2^WIDTH, e.g. WIDTH=32: 0xFFFFFFFF+1 → 0 with cout=1.
- Invalid parameters: WIDTH % STAGES != 0 must be rejected at elaboration via a generate-time error.

Optional Feature:
PIPE_ADDER_SAT_EN
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and carried through the pipe.
  - When sat=1 and ovf=1, y clamps to the signed maximum (0x7FFF…F) if the true result is positive, else to the signed minimum (0x800…0).
  - ovf still reports the raw overflow; cout is unaffected.
  - zero reflects the clamped y.
- Not defined: sat port is absent; results always wrap.

Test Plan:
1. WIDTH=32, STAGES=2, a=0x00000003, b=0x00000004, sub=0, out_ready=1 → out_valid two cycles after accept; y=0x00000007, cout=0, ovf=0, zero=0.
2. a=0xFFFFFFFF, b=0x00000001, sub=0 → y=0x00000000, cout=1, ovf=0, zero=1. Also a=0x7FFFFFFF, b=1 → y=0x80000000, ovf=1, cout=0.
3. sub=1, a=5, b=7 → y=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 → y=2, cout=1.
4. Stream 8 back-to-back beats (a=i, b=0x100·i); hold out_ready=0 for 3 cycles mid-stream → in_ready drops, outputs appear in order as y=0x101·i, none lost or duplicated, y stable during the stall.
5. Accept 2 beats, assert rst_n=0 asynchronously between edges → out_valid=0 immediately; after release, no stale beat emerges; a new beat 1+1 → y=2 at normal latency. Repeat test 1 with STAGES=1 (latency 1) and STAGES=4 (latency 4).
6. (PIPE_ADDER_SAT_EN) sat=1: 0x7FFFFFFF+1 → y=0x7FFFFFFF, ovf=1. 0x80000000−1 (sub) → y=0x80000000, ovf=1. With sat=0, the same inputs wrap to 0x80000000 and 0x7FFFFFFF.
